// File: rtl/parity_sched_pkg.sv
// Shared types and constants for the parity_sched block: word width,
// evaluation-counter width and the controller state encoding.
package parity_sched_pkg;

  localparam int WORD_W = 16;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    EVAL   = 2'd2,
    RESP   = 2'd3
  } state_e;

  // Even/odd parity of one operand word, as the evaluator is expected to compute it.
  function automatic logic word_parity(input logic [WORD_W-1:0] w);
    return ^w;
  endfunction

endpackage

// File: rtl/parity_sched_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requesting index at or
// after ptr, wrapping modulo N. The pointer register lives in the caller.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             en,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [2*N-1:0]   req_dbl;
  logic [2*N-1:0]   req_shift;
  logic [N-1:0]     req_rot;
  logic [IDX_W-1:0] off;
  logic             found;
  logic [IDX_W:0]   sum;

  assign req_dbl   = {req, req};
  assign req_shift = req_dbl >> ptr;
  assign req_rot   = req_shift[N-1:0];

  // Priority-pick the lowest set bit of the rotated request vector, then
  // translate that offset back into an absolute requester index.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    off   = '0;
    found = 1'b0;
    for (int j = N - 1; j >= 0; j--) begin
      if (req_rot[j]) begin
        off   = IDX_W'(j);
        found = 1'b1;
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (IDX_W + 1)'(N)) begin
      sum = sum - (IDX_W + 1)'(N);
    end
    any = found & en;
    idx = any ? sum[IDX_W-1:0] : '0;
    gnt = '0;
    for (int j = 0; j < N; j++) begin
      gnt[j] = any && (idx == IDX_W'(j));
    end
  end

endmodule

// File: rtl/parity_sched.sv
// parity_sched: shares one external 16-input parity evaluator between NREQ
// requesters with packet-granular round-robin arbitration. Each word is
// launched into the evaluator, its result is XOR-accumulated, and one
// (id, parity) response is returned per packet.
// Optional build macro PARITY_SCHED_CHECK_EN adds a sticky chk_err output that
// flags an evaluator result disagreeing with a local reduction of pu_data.
module parity_sched
  import parity_sched_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int EVAL_CYCLES = 3,
  parameter int ID_W        = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [WORD_W*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]        req_last,
  output logic [NREQ-1:0]        req_ready,
  output logic [WORD_W-1:0]      pu_data,
  output logic                   pu_start,
  input  logic                   pu_q,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic                   rsp_parity
`ifdef PARITY_SCHED_CHECK_EN
  ,
  output logic                   chk_err
`endif
);

  state_e              state_q, state_d;
  logic [ID_W-1:0]     owner_q, owner_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic                owned_q, owned_d;
  logic                last_q, last_d;
  logic                acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WORD_W-1:0]   pu_data_q, pu_data_d;

  logic [WORD_W-1:0]   words [NREQ];
  logic [NREQ-1:0]     arb_gnt;
  logic [ID_W-1:0]     arb_idx;
  logic                arb_any;
  logic [ID_W-1:0]     sel_idx;
  logic                sel_valid;
  logic                accept;
  logic                eval_done;
  logic                rsp_fire;
  logic [NREQ-1:0]     owner_onehot;

  for (genvar g = 0; g < NREQ; g++) begin : g_words
    assign words[g] = req_data[g*WORD_W +: WORD_W];
  end

  // New owners are only chosen while no packet is open.
  rr_arbiter #(
    .N     (NREQ),
    .IDX_W (ID_W)
  ) u_arb (
    .req (req_valid),
    .ptr (ptr_q),
    .en  (!owned_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  assign sel_idx      = owned_q ? owner_q : arb_idx;
  assign sel_valid    = owned_q ? req_valid[owner_q] : arb_any;
  assign accept       = (state_q == IDLE) && sel_valid && !rst;
  assign eval_done    = (state_q == EVAL) && (cnt_q == '0);
  assign rsp_fire     = (state_q == RESP) && rsp_ready;
  assign owner_onehot = NREQ'(1) << owner_q;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is written with non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: accept -> launch -> evaluate -> (respond | next word).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = LAUNCH;
      LAUNCH:  state_d = EVAL;
      EVAL:    if (cnt_q == '0) state_d = last_q ? RESP : IDLE;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: consume strobe, evaluator launch and response valid.
  always_comb begin
    req_ready = '0;
    pu_start  = 1'b0;
    rsp_valid = 1'b0;
    unique case (state_q)
      IDLE:    if (accept) req_ready = owned_q ? owner_onehot : arb_gnt;
      LAUNCH:  pu_start = 1'b1;
      RESP:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath next-state: word capture, ownership, eval countdown, accumulator.
  always_comb begin
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    owned_d   = owned_q;
    last_d    = last_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    pu_data_d = pu_data_q;

    if (accept) begin
      pu_data_d = words[sel_idx];
      last_d    = req_last[sel_idx];
      owner_d   = sel_idx;
      owned_d   = 1'b1;
    end

    if (state_q == LAUNCH) begin
      cnt_d = CNT_W'(EVAL_CYCLES - 1);
    end else if ((state_q == EVAL) && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end

    if (eval_done) begin
      acc_d = acc_q ^ pu_q;
    end

    if (rsp_fire) begin
      acc_d   = 1'b0;
      owned_d = 1'b0;
      ptr_d   = (owner_q == ID_W'(NREQ - 1)) ? '0 : owner_q + 1'b1;
    end
  end

  // Datapath registers; a reset abandons any open packet.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q   <= '0;
      ptr_q     <= '0;
      owned_q   <= 1'b0;
      last_q    <= 1'b0;
      acc_q     <= 1'b0;
      cnt_q     <= '0;
      pu_data_q <= '0;
    end else begin
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      owned_q   <= owned_d;
      last_q    <= last_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      pu_data_q <= pu_data_d;
    end
  end

  assign pu_data    = pu_data_q;
  assign rsp_id     = owner_q;
  assign rsp_parity = acc_q;

`ifdef PARITY_SCHED_CHECK_EN
  logic chk_err_q;

  // Sticky flag: evaluator result disagrees with the locally reduced operand.
  always_ff @(posedge clk) begin
    if (rst) begin
      chk_err_q <= 1'b0;
    end else if (eval_done && (pu_q != word_parity(pu_data_q))) begin
      chk_err_q <= 1'b1;
    end
  end

  assign chk_err = chk_err_q;
`endif

endmodule

// File: tb/tb_parity_sched.sv
// Self-checking bench for parity_sched: randomized and directed packet traffic,
// an external evaluator modelled as a delayed XOR, and a monitor that checks
// grants, launches and responses against a round-robin packet model.
module tb_parity_sched;

  localparam int NREQ = 4;
  localparam int EVAL = 3;
  localparam int ID_W = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NREQ-1:0]    req_valid = '0;
  logic [16*NREQ-1:0] req_data  = '0;
  logic [NREQ-1:0]    req_last  = '0;
  logic [NREQ-1:0]    req_ready;
  logic [15:0]        pu_data;
  logic               pu_start;
  logic               pu_q;
  logic               rsp_valid;
  logic               rsp_ready = 1'b0;
  logic [ID_W-1:0]    rsp_id;
  logic               rsp_parity;
`ifdef PARITY_SCHED_CHECK_EN
  logic               chk_err;
`endif

  parity_sched #(
    .NREQ        (NREQ),
    .EVAL_CYCLES (EVAL),
    .ID_W        (ID_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .pu_data    (pu_data),
    .pu_start   (pu_start),
    .pu_q       (pu_q),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_parity (rsp_parity)
`ifdef PARITY_SCHED_CHECK_EN
    ,
    .chk_err    (chk_err)
`endif
  );

  // Evaluator model: parity of the launched operand appears EVAL cycles after pu_start.
  logic pipe [EVAL];
  int   start_cnt = 0;
  int   inj_at    = -1;
  int   cyc       = 0;

  always @(posedge clk) begin
    pipe[0] <= pu_start ? (($countones(pu_data) % 2 == 1) ^ (start_cnt == inj_at)) : 1'($urandom);
    for (int k = 1; k < EVAL; k++) pipe[k] <= pipe[k-1];
    if (pu_start) start_cnt <= start_cnt + 1;
    cyc <= cyc + 1;
  end
  assign pu_q = pipe[EVAL-1];

  typedef struct {
    logic [15:0] data;
    logic        last;
    int          gap;
  } word_t;

  word_t wq[NREQ][$];
  bit    exp_par[NREQ][$];
  bit    open_par[NREQ];
  int    gapc[NREQ];
  bit    started[NREQ];
  bit    consumed[NREQ];
  int    rsp_block = 0;
  bit    rsp_rand  = 0;

  int n_checks = 0;
  int n_errs   = 0;

  // Reference model state.
  bit          m_open, m_rsp_pend;
  int          m_owner, m_ptr, m_free, exp_start, exp_rsp;
  logic [15:0] exp_word;

  // Observations of the DUT used by directed checks.
  int n_starts = 0, n_rsp_cycles = 0, max_ones = 0;
  int grant_cyc = 0, start_cyc = 0, rsp_rise_cyc = 0;
  bit prev_rv = 0;
  int last_rsp_id = 0;
  bit last_rsp_par = 0;
  int dlog[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic add_word(input int i, input logic [15:0] d, input logic last, input int gap);
    word_t w;
    w.data = d;
    w.last = last;
    w.gap  = gap;
    wq[i].push_back(w);
    open_par[i] = open_par[i] ^ ($countones(d) % 2 == 1);
    if (last) begin
      exp_par[i].push_back(open_par[i]);
      open_par[i] = 1'b0;
    end
  endtask

  // One clock of stimulus: note consumption at negedge, present next inputs after posedge.
  task automatic step();
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) consumed[i] = req_valid[i] && req_ready[i];
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (consumed[i]) begin
        wq[i].delete(0);
        started[i] = 0;
      end
      if (wq[i].size() != 0) begin
        if (!started[i]) begin
          gapc[i]    = wq[i][0].gap;
          started[i] = 1;
        end
        if (gapc[i] > 0) begin
          req_valid[i] = 1'b0;
          req_data[16*i +: 16] = 16'($urandom);
          gapc[i]--;
        end else begin
          req_valid[i] = 1'b1;
          req_data[16*i +: 16] = wq[i][0].data;
          req_last[i] = wq[i][0].last;
        end
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
        req_data[16*i +: 16] = 16'($urandom);
      end
    end
    if (rsp_block > 0) begin
      rsp_ready = 1'b0;
      if (rsp_valid) rsp_block--;
    end else begin
      rsp_ready = rsp_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    bit busy;
    n    = 0;
    busy = 1;
    while (busy && n < budget) begin
      step();
      n++;
      busy = m_open || m_rsp_pend;
      for (int i = 0; i < NREQ; i++) busy |= (wq[i].size() != 0) || (exp_par[i].size() != 0);
    end
    check("idle_timeout", 32'(busy), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      wq[i].delete();
      exp_par[i].delete();
      open_par[i] = 0;
      started[i]  = 0;
      gapc[i]     = 0;
      consumed[i] = 0;
    end
    req_valid = '0;
    req_last  = '0;
    rsp_block = 0;
    rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_pu_start", pu_start, 0);
    check("rst_pu_data", pu_data, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_parity", rsp_parity, 0);
`ifdef PARITY_SCHED_CHECK_EN
    check("rst_chk_err", chk_err, 0);
`endif
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares DUT outputs each cycle against the packet-level model.
  task automatic monitor_cycle();
    logic [NREQ-1:0] exp_rdy;
    int cand;
    bit can_grant, exp_rv;
    if (rst) begin
      m_open = 0; m_rsp_pend = 0; m_owner = 0; m_ptr = 0; m_free = 0;
      exp_start = -1; exp_rsp = -1; prev_rv = 0;
      return;
    end
    if (pu_start) begin n_starts++; start_cyc = cyc; end
    if (rsp_valid) n_rsp_cycles++;
    if (rsp_valid && !prev_rv) rsp_rise_cyc = cyc;
    prev_rv = rsp_valid;
    if ($countones(req_ready) > max_ones) max_ones = $countones(req_ready);
    if (req_ready != '0) begin
      grant_cyc = cyc;
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) dlog.push_back(i);
    end

    if (pu_start || cyc == exp_start) begin
      check("pu_start", pu_start, 32'(cyc == exp_start));
      if (cyc == exp_start) check("pu_data", pu_data, exp_word);
    end

    can_grant = !m_rsp_pend && (cyc >= m_free);
    cand      = m_open ? (req_valid[m_owner] ? m_owner : -1) : rr_pick(req_valid, m_ptr);
    exp_rdy   = (can_grant && cand >= 0) ? (NREQ'(1) << cand) : '0;
    if (req_ready != '0 || exp_rdy != '0) check("req_ready", req_ready, exp_rdy);
    if (exp_rdy != '0) begin
      m_open    = 1;
      m_owner   = cand;
      exp_word  = req_data[16*cand +: 16];
      exp_start = cyc + 1;
      if (req_last[cand]) begin
        m_rsp_pend = 1;
        exp_rsp    = cyc + 2 + EVAL;
      end else begin
        m_free = cyc + 2 + EVAL;
      end
    end

    exp_rv = m_rsp_pend && (cyc >= exp_rsp);
    if (rsp_valid || exp_rv) check("rsp_valid", rsp_valid, 32'(exp_rv));
    if (rsp_valid && exp_rv) begin
      check("rsp_id", rsp_id, m_owner);
      check("rsp_pkt_known", 32'(exp_par[m_owner].size() != 0), 1);
      if (exp_par[m_owner].size() != 0) check("rsp_parity", rsp_parity, exp_par[m_owner][0]);
      if (rsp_ready) begin
        last_rsp_id  = int'(rsp_id);
        last_rsp_par = rsp_parity;
        if (exp_par[m_owner].size() != 0) void'(exp_par[m_owner].pop_front());
        m_open     = 0;
        m_rsp_pend = 0;
        m_ptr      = (m_owner + 1) % NREQ;
        m_free     = cyc + 1;
      end
    end
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        monitor_cycle();
      end
      begin : stim
        int n0, r0, n, pi;
        do_reset();

        // Single word on requester 2: accept t, launch t+1, response t+2+EVAL.
        add_word(2, 16'h0001, 1'b1, 0);
        wait_idle(50);
        check("t2_launch_lat", start_cyc - grant_cyc, 1);
        check("t2_rsp_lat", rsp_rise_cyc - grant_cyc, 2 + EVAL);
        check("t2_rsp_id", last_rsp_id, 2);
        check("t2_rsp_par", last_rsp_par, 1);

        // Three-word packet on requester 0.
        n0 = n_starts;
        add_word(0, 16'hFFFF, 1'b0, 0);
        add_word(0, 16'h0003, 1'b0, 0);
        add_word(0, 16'h0100, 1'b1, 0);
        wait_idle(100);
        check("t3_starts", n_starts - n0, 3);
        check("t3_rsp_id", last_rsp_id, 0);
        check("t3_rsp_par", last_rsp_par, 1);

        // All requesters busy with single-word packets.
        do_reset();
        dlog.delete();
        max_ones = 0;
        for (int rep = 0; rep < 2; rep++)
          for (int i = 0; i < NREQ; i++) add_word(i, 16'($urandom), 1'b1, 0);
        wait_idle(300);
        check("t4_grants", dlog.size(), 8);
        for (int k = 0; k < dlog.size() && k < 8; k++) check("t4_order", dlog[k], k % NREQ);
        check("t4_max_ready_bits", max_ones, 1);

        // Owner drops valid mid-packet while requester 3 waits.
        dlog.delete();
        add_word(1, 16'($urandom), 1'b0, 0);
        add_word(1, 16'($urandom), 1'b0, 10);
        add_word(1, 16'($urandom), 1'b1, 0);
        add_word(3, 16'($urandom), 1'b1, 2);
        wait_idle(300);
        check("t5_grants", dlog.size(), 4);
        if (dlog.size() == 4) begin
          check("t5_g0", dlog[0], 1);
          check("t5_g1", dlog[1], 1);
          check("t5_g2", dlog[2], 1);
          check("t5_g3", dlog[3], 3);
        end

        // Response back-pressure for 7 cycles with another requester waiting.
        dlog.delete();
        r0 = n_rsp_cycles;
        rsp_block = 7;
        add_word(2, 16'hA5A4, 1'b1, 0);
        add_word(0, 16'($urandom), 1'b1, 3);
        wait_idle(200);
        check("t6_rsp_cycles", n_rsp_cycles - r0, 9);
        check("t6_grants", dlog.size(), 2);
        if (dlog.size() == 2) begin
          check("t6_g0", dlog[0], 2);
          check("t6_g1", dlog[1], 0);
        end

        // Reset while a word is being evaluated.
        n0 = n_starts;
        add_word(0, 16'hBEEF, 1'b1, 0);
        n = 0;
        while (n_starts == n0 && n < 20) begin
          step();
          n++;
        end
        check("t7_launch_seen", 32'(n_starts > n0), 1);
        step();
        do_reset();
        r0 = n_rsp_cycles;
        for (int k = 0; k < 12; k++) step();
        check("t7_no_rsp", n_rsp_cycles - r0, 0);

        // Randomized traffic with random gaps and random response acceptance.
        rsp_rand = 1;
        for (int p = 0; p < 150; p++) begin
          pi = $urandom_range(0, NREQ - 1);
          n  = $urandom_range(1, 4);
          for (int w = 0; w < n; w++)
            add_word(pi, 16'($urandom), 1'(w == n - 1), $urandom_range(0, 3));
        end
        wait_idle(20000);
        rsp_rand = 0;

`ifdef PARITY_SCHED_CHECK_EN
        // Evaluator returns one wrong result: chk_err sets and holds until reset.
        do_reset();
        inj_at = start_cnt;
        add_word(0, 16'h0007, 1'b1, 0);
        exp_par[0][0] = ~exp_par[0][0];
        wait_idle(100);
        inj_at = -1;
        check("t9_chk_set", chk_err, 1);
        add_word(1, 16'($urandom), 1'b1, 0);
        add_word(2, 16'($urandom), 1'b1, 0);
        wait_idle(100);
        check("t9_chk_sticky", chk_err, 1);
        do_reset();
`endif
      end
    join_any
    disable fork;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
